// File: rtl/exec_step_controller.sv
// Instruction-step sequencer: turns step/run/halt button pulses into a processor enable window.
// Optional BREAKPOINT_EN adds Pc/BpAddr ports and stops free-run on a PC match.
module exec_step_controller #(
   parameter int INSTR_CYCLES = 3,
   parameter int CNT_W        = 16
`ifdef BREAKPOINT_EN
   ,
   parameter int PC_W         = 8
`endif
) (
   input  logic             Clk,
   input  logic             ResetN,
   input  logic             StepP,
   input  logic             RunP,
   input  logic             HaltP,
   input  logic             HaltInstr,
`ifdef BREAKPOINT_EN
   input  logic [PC_W-1:0]  Pc,
   input  logic [PC_W-1:0]  BpAddr,
`endif
   output logic             CpuEn,
   output logic             InstrDone,
   output logic             Running,
   output logic [CNT_W-1:0] InstrCount
);

   // state      | meaning
   // S_IDLE     | processor gated off, waiting for a step or run pulse
   // S_STEP     | executing exactly one atomic instruction
   // S_RUN      | free-running, instruction after instruction
   // S_STOPPING | halt requested mid-instruction, finishing it before idling
   typedef enum logic [1:0] {
      S_IDLE,
      S_STEP,
      S_RUN,
      S_STOPPING
   } state_t;

   localparam int CYC_W = (INSTR_CYCLES > 1) ? $clog2(INSTR_CYCLES) : 1;
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(INSTR_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CYC_W-1:0] cyc;
   logic             boundary;
   logic             bp_hit;

`ifdef BREAKPOINT_EN
   assign bp_hit = (Pc == BpAddr);
`else
   assign bp_hit = 1'b0;
`endif

   assign boundary  = (state != S_IDLE) && (cyc == CYC_LAST);
   assign CpuEn     = (state != S_IDLE);
   assign Running   = (state == S_RUN) || (state == S_STOPPING);
   assign InstrDone = boundary;

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state      <= S_IDLE;
         cyc        <= '0;
         InstrCount <= '0;
      end else begin
         state <= state_nxt;
         if ((state == S_IDLE) || boundary) begin
            cyc <= '0;
         end else begin
            cyc <= cyc + 1'b1;
         end
         if (boundary) begin
            InstrCount <= InstrCount + 1'b1;
         end
      end
   end

   // With a single-cycle instruction every enabled cycle is a boundary, so S_STOPPING is unreachable.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (HaltP) begin
               state_nxt = S_IDLE;
            end else if (RunP) begin
               state_nxt = S_RUN;
            end else if (StepP) begin
               state_nxt = S_STEP;
            end
         end
         S_STEP: begin
            if (boundary) begin
               state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (boundary) begin
               if (HaltP || HaltInstr || bp_hit) begin
                  state_nxt = S_IDLE;
               end
            end else if (HaltP) begin
               state_nxt = S_STOPPING;
            end
         end
         S_STOPPING: begin
            if (boundary) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_exec_step_controller.sv
// Bench for exec_step_controller: vector table through a scoreboard, plus directed multi-cycle sequences.
// A second instance with single-cycle instructions and a 4-bit counter covers wrap and the no-STOPPING case.
module tb_exec_step_controller;

   logic        Clk = 1'b0;
   logic        ResetN;
   logic        StepP, RunP, HaltP, HaltInstr;
   logic [7:0]  Pc, BpAddr;
   logic        CpuEn, InstrDone, Running;
   logic [15:0] InstrCount;

   logic        b_step, b_run, b_halt, b_hi;
   logic [7:0]  b_pc;
   logic        b_en, b_done, b_running;
   logic [3:0]  b_cnt;

   always #5 Clk = ~Clk;

   exec_step_controller #(.INSTR_CYCLES(3), .CNT_W(16)) dut (
      .Clk(Clk), .ResetN(ResetN), .StepP(StepP), .RunP(RunP), .HaltP(HaltP), .HaltInstr(HaltInstr),
`ifdef BREAKPOINT_EN
      .Pc(Pc), .BpAddr(BpAddr),
`endif
      .CpuEn(CpuEn), .InstrDone(InstrDone), .Running(Running), .InstrCount(InstrCount)
   );

   exec_step_controller #(.INSTR_CYCLES(1), .CNT_W(4)) dut_b (
      .Clk(Clk), .ResetN(ResetN), .StepP(b_step), .RunP(b_run), .HaltP(b_halt), .HaltInstr(b_hi),
`ifdef BREAKPOINT_EN
      .Pc(b_pc), .BpAddr(BpAddr),
`endif
      .CpuEn(b_en), .InstrDone(b_done), .Running(b_running), .InstrCount(b_cnt)
   );

   typedef struct {
      logic        step, run, halt, hinstr;
      logic        en, done, running;
      logic [15:0] cnt;
   } vec_t;

   typedef struct {
      logic        en, done, running;
      logic [15:0] cnt;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   exp_cnt;
   int   dones;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic s, r, h, hi, en, d, run, input logic [15:0] cnt);
      vec_t v;
      v.step = s; v.run = r; v.halt = h; v.hinstr = hi;
      v.en = en; v.done = d; v.running = run; v.cnt = cnt;
      return v;
   endfunction

   // Called at a falling edge: drive one cycle of inputs, queue the expectation, check it one cycle later.
   task automatic apply(input vec_t v, input int idx);
      exp_t e;
      StepP = v.step; RunP = v.run; HaltP = v.halt; HaltInstr = v.hinstr;
      e.en = v.en; e.done = v.done; e.running = v.running; e.cnt = v.cnt;
      sb.push_back(e);
      @(negedge Clk);
      e = sb.pop_front();
      chk($sformatf("vec%0d CpuEn", idx), 32'(CpuEn), 32'(e.en));
      chk($sformatf("vec%0d InstrDone", idx), 32'(InstrDone), 32'(e.done));
      chk($sformatf("vec%0d Running", idx), 32'(Running), 32'(e.running));
      chk($sformatf("vec%0d InstrCount", idx), 32'(InstrCount), 32'(e.cnt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //         step run halt hi | en done run cnt
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'd0));
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 16'd0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 16'd0));
      tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 16'd0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'd1));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 16'd1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'd1));
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1, 16'd1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 16'd1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 16'd1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 16'd2));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 16'd2));
      tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 16'd2));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16'd3));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'd3));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 16'd3));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 16'd3));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 16'd3));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 16'd4));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'd4));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 16'd4));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 16'd4));
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 16'd4));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 16'd5));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 16'd5));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 16'd5));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 16'd6));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 16'd6));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 16'd6));

      // Reset held with every pulse asserted
      ResetN = 1'b0;
      StepP = 1'b1; RunP = 1'b1; HaltP = 1'b1; HaltInstr = 1'b1;
      b_step = 1'b1; b_run = 1'b1; b_halt = 1'b0; b_hi = 1'b0;
      Pc = 8'h00; b_pc = 8'h00; BpAddr = 8'h05;
      repeat (3) @(negedge Clk);
      chk("rst CpuEn", 32'(CpuEn), 32'd0);
      chk("rst InstrDone", 32'(InstrDone), 32'd0);
      chk("rst Running", 32'(Running), 32'd0);
      chk("rst InstrCount", 32'(InstrCount), 32'd0);
      chk("rst b CpuEn", 32'(b_en), 32'd0);
      StepP = 1'b0; RunP = 1'b0; HaltP = 1'b0; HaltInstr = 1'b0;
      b_step = 1'b0; b_run = 1'b0;
      ResetN = 1'b1;
      @(negedge Clk);
      chk("post-rst CpuEn", 32'(CpuEn), 32'd0);
      chk("post-rst InstrCount", 32'(InstrCount), 32'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], i);
      end
      StepP = 1'b0; RunP = 1'b0; HaltP = 1'b0; HaltInstr = 1'b0;
      exp_cnt = 6;

      // Run, halt on Cyc=0 of the 4th instruction: exactly 4 instructions retire
      RunP = 1'b1;
      @(negedge Clk);
      RunP = 1'b0;
      dones = 0;
      for (int i = 0; i < 40 && dones < 3; i++) begin
         if (InstrDone) dones++;
         if (dones < 3) @(negedge Clk);
      end
      chk("t3 three dones", 32'(dones), 32'd3);
      @(negedge Clk);
      chk("t3 4th cyc0 InstrDone", 32'(InstrDone), 32'd0);
      chk("t3 4th cyc0 count", 32'(InstrCount), 32'(exp_cnt + 3));
      HaltP = 1'b1;
      @(negedge Clk);
      HaltP = 1'b0;
      chk("t3 stopping Running", 32'(Running), 32'd1);
      chk("t3 stopping CpuEn", 32'(CpuEn), 32'd1);
      for (int i = 0; i < 20; i++) begin
         if (InstrDone) dones++;
         if (!CpuEn) break;
         @(negedge Clk);
      end
      chk("t3 CpuEn dropped", 32'(CpuEn), 32'd0);
      chk("t3 done pulses", 32'(dones), 32'd4);
      chk("t3 Running", 32'(Running), 32'd0);
      chk("t3 InstrCount", 32'(InstrCount), 32'(exp_cnt + 4));
      exp_cnt = exp_cnt + 4;

`ifdef BREAKPOINT_EN
      // Pc matches from the first cycle; only the boundary sample stops the run
      RunP = 1'b1;
      @(negedge Clk);
      RunP = 1'b0;
      Pc = 8'h05;
      @(negedge Clk);
      chk("bp non-boundary CpuEn", 32'(CpuEn), 32'd1);
      @(negedge Clk);
      chk("bp boundary InstrDone", 32'(InstrDone), 32'd1);
      @(negedge Clk);
      chk("bp stop CpuEn", 32'(CpuEn), 32'd0);
      chk("bp stop count", 32'(InstrCount), 32'(exp_cnt + 1));
      StepP = 1'b1;
      @(negedge Clk);
      StepP = 1'b0;
      repeat (3) @(negedge Clk);
      chk("bp step CpuEn", 32'(CpuEn), 32'd0);
      chk("bp step count", 32'(InstrCount), 32'(exp_cnt + 2));
      Pc = 8'h00;
      exp_cnt = exp_cnt + 2;
`endif

      // Reset mid-instruction aborts immediately and clears the count
      StepP = 1'b1;
      @(negedge Clk);
      StepP = 1'b0;
      chk("abort pre CpuEn", 32'(CpuEn), 32'd1);
      chk("abort pre count", 32'(InstrCount), 32'(exp_cnt));
      @(posedge Clk);
      #2 ResetN = 1'b0;
      #1;
      chk("abort CpuEn", 32'(CpuEn), 32'd0);
      chk("abort Running", 32'(Running), 32'd0);
      chk("abort InstrCount", 32'(InstrCount), 32'd0);
      @(negedge Clk);
      ResetN = 1'b1;
      @(negedge Clk);
      chk("abort idle CpuEn", 32'(CpuEn), 32'd0);
      chk("abort idle count", 32'(InstrCount), 32'd0);

      // Single-cycle instructions: 17 retire, 4-bit counter wraps to 1
      b_run = 1'b1;
      @(negedge Clk);
      b_run = 1'b0;
      chk("b run CpuEn", 32'(b_en), 32'd1);
      chk("b run InstrDone", 32'(b_done), 32'd1);
      chk("b run count", 32'(b_cnt), 32'd0);
      for (int i = 1; i <= 16; i++) begin
         @(negedge Clk);
         chk($sformatf("b count %0d", i), 32'(b_cnt), 32'(i % 16));
      end
      chk("b running", 32'(b_running), 32'd1);
      b_halt = 1'b1;
      @(negedge Clk);
      b_halt = 1'b0;
      chk("b halt CpuEn", 32'(b_en), 32'd0);
      chk("b halt Running", 32'(b_running), 32'd0);
      chk("b wrap count", 32'(b_cnt), 32'd1);
      b_run = 1'b1;
      @(negedge Clk);
      b_run = 1'b0;
      b_hi = 1'b1;
      @(negedge Clk);
      b_hi = 1'b0;
      chk("b hinstr CpuEn", 32'(b_en), 32'd0);
      chk("b hinstr count", 32'(b_cnt), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
